// File: rtl/cacop_ctrl.sv
// CACOP maintenance sequencer: accepts a commit-stage CACOP, drives the selected
// cache maintenance port until it acknowledges, and bounds the wait with a watchdog.
module cacop_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cacop_valid_i,
    input  logic [4:0]  cacop_op_i,
    input  logic [31:0] cacop_vaddr_i,
    input  logic [31:0] cacop_paddr_i,
    output logic        ready_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic        icache_req_o,
    output logic [1:0]  icache_mode_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_ack_i,
    output logic        dcache_req_o,
    output logic [1:0]  dcache_mode_o,
    output logic [31:0] dcache_addr_o,
    input  logic        dcache_ack_i
);

    localparam int unsigned     CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q;
    logic [2:0]    target_q;
    logic [1:0]    mode_q;
    logic [31:0]   addr_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

    logic op_noop;
    logic sel_ack;
    logic timeout;

    assign op_noop = (cacop_op_i[4:3] == 2'd3) || (cacop_op_i[2:0] > 3'd1);
    // Only the targeted cache's ack counts; the other is ignored.
    assign sel_ack = (target_q == 3'd0) ? icache_ack_i : dcache_ack_i;
    assign timeout = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            mode_q   <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cacop_valid_i) begin
                        target_q <= cacop_op_i[2:0];
                        mode_q   <= cacop_op_i[4:3];
                        addr_q   <= (cacop_op_i[4:3] == 2'd2) ? cacop_paddr_i : cacop_vaddr_i;
                        err_q    <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= op_noop ? DONE : REQ;
                    end
                end
                REQ: begin
                    // Ack takes priority over a coincident timeout.
                    if (sel_ack) begin
                        state_q <= DONE;
                    end else begin
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (timeout) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o       = (state_q == IDLE);
    assign stall_o       = (state_q == REQ) || ((state_q == IDLE) && cacop_valid_i);
    assign done_o        = (state_q == DONE);
    assign err_o         = (state_q == DONE) && err_q;
    assign icache_req_o  = (state_q == REQ) && (target_q == 3'd0);
    assign dcache_req_o  = (state_q == REQ) && (target_q == 3'd1);
    assign icache_mode_o = mode_q;
    assign icache_addr_o = addr_q;
    assign dcache_mode_o = mode_q;
    assign dcache_addr_o = addr_q;

endmodule

// File: tb/tb_cacop_ctrl.sv
// Self-checking bench for cacop_ctrl: directed scenarios plus randomized ops checked
// cycle by cycle against a transaction-level expectation of request length and result.
module tb_cacop_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cacop_valid_i;
    logic [4:0]  cacop_op_i;
    logic [31:0] cacop_vaddr_i;
    logic [31:0] cacop_paddr_i;
    logic        ready_o, stall_o, done_o, err_o;
    logic        icache_req_o, dcache_req_o;
    logic [1:0]  icache_mode_o, dcache_mode_o;
    logic [31:0] icache_addr_o, dcache_addr_o;
    logic        icache_ack_i, dcache_ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    cacop_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .cacop_valid_i (cacop_valid_i),
        .cacop_op_i    (cacop_op_i),
        .cacop_vaddr_i (cacop_vaddr_i),
        .cacop_paddr_i (cacop_paddr_i),
        .ready_o       (ready_o),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .icache_req_o  (icache_req_o),
        .icache_mode_o (icache_mode_o),
        .icache_addr_o (icache_addr_o),
        .icache_ack_i  (icache_ack_i),
        .dcache_req_o  (dcache_req_o),
        .dcache_mode_o (dcache_mode_o),
        .dcache_addr_o (dcache_addr_o),
        .dcache_ack_i  (dcache_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle(input bit stray);
        @(negedge clk);
        cacop_valid_i = 1'b0;
        icache_ack_i  = stray ? 1'($urandom) : 1'b0;
        dcache_ack_i  = stray ? 1'($urandom) : 1'b0;
        #1;
        chk("idle_ready", 32'(ready_o), 32'd1);
        chk("idle_stall", 32'(stall_o), 32'd0);
        chk("idle_done",  32'(done_o),  32'd0);
        chk("idle_ireq",  32'(icache_req_o), 32'd0);
        chk("idle_dreq",  32'(dcache_req_o), 32'd0);
    endtask

    // ack_at: REQ-cycle index (0 = first request cycle) at which the selected cache
    // acks; any value outside 0..TMO-1 means the watchdog fires first.
    task automatic run_op(input logic [4:0] op, input logic [31:0] va, input logic [31:0] pa,
                          input int ack_at, input bit stray);
        logic [2:0]  tgt;
        logic [1:0]  mode;
        logic [31:0] exp_addr;
        bit          noop, exp_err;
        int          len;
        tgt      = op[2:0];
        mode     = op[4:3];
        noop     = (mode == 2'd3) || (tgt > 3'd1);
        exp_addr = (mode == 2'd2) ? pa : va;
        if (ack_at >= 0 && ack_at < TMO) begin
            len = ack_at + 1;
            exp_err = 1'b0;
        end else begin
            len = TMO;
            exp_err = 1'b1;
        end
        if (noop) exp_err = 1'b0;

        @(negedge clk);
        cacop_valid_i = 1'b1;
        cacop_op_i    = op;
        cacop_vaddr_i = va;
        cacop_paddr_i = pa;
        icache_ack_i  = stray ? 1'($urandom) : 1'b0;
        dcache_ack_i  = stray ? 1'($urandom) : 1'b0;
        #1;
        chk("acc_ready", 32'(ready_o), 32'd1);
        chk("acc_stall", 32'(stall_o), 32'd1);
        chk("acc_done",  32'(done_o),  32'd0);
        chk("acc_ireq",  32'(icache_req_o), 32'd0);
        chk("acc_dreq",  32'(dcache_req_o), 32'd0);

        if (!noop) begin
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                if (tgt == 3'd0) begin
                    icache_ack_i = (i == ack_at);
                    dcache_ack_i = stray ? 1'($urandom) : 1'b0;
                end else begin
                    dcache_ack_i = (i == ack_at);
                    icache_ack_i = stray ? 1'($urandom) : 1'b0;
                end
                #1;
                chk("req_ireq",  32'(icache_req_o), 32'(tgt == 3'd0));
                chk("req_dreq",  32'(dcache_req_o), 32'(tgt == 3'd1));
                chk("req_stall", 32'(stall_o), 32'd1);
                chk("req_ready", 32'(ready_o), 32'd0);
                chk("req_done",  32'(done_o),  32'd0);
                if (tgt == 3'd0) begin
                    chk("req_imode", 32'(icache_mode_o), 32'(mode));
                    chk("req_iaddr", icache_addr_o, exp_addr);
                end else begin
                    chk("req_dmode", 32'(dcache_mode_o), 32'(mode));
                    chk("req_daddr", dcache_addr_o, exp_addr);
                end
            end
        end

        @(negedge clk);
        icache_ack_i = stray ? 1'($urandom) : 1'b0;
        dcache_ack_i = stray ? 1'($urandom) : 1'b0;
        #1;
        chk("done_done",  32'(done_o),  32'd1);
        chk("done_err",   32'(err_o),   32'(exp_err));
        chk("done_stall", 32'(stall_o), 32'd0);
        chk("done_ready", 32'(ready_o), 32'd0);
        chk("done_ireq",  32'(icache_req_o), 32'd0);
        chk("done_dreq",  32'(dcache_req_o), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        cacop_valid_i = 1'b0;
        cacop_op_i    = '0;
        cacop_vaddr_i = '0;
        cacop_paddr_i = '0;
        icache_ack_i  = 1'b0;
        dcache_ack_i  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_done",  32'(done_o),  32'd0);
        chk("rst_err",   32'(err_o),   32'd0);
        chk("rst_ireq",  32'(icache_req_o), 32'd0);
        chk("rst_dreq",  32'(dcache_req_o), 32'd0);
        chk("rst_imode", 32'(icache_mode_o), 32'd0);
        chk("rst_dmode", 32'(dcache_mode_o), 32'd0);
        chk("rst_iaddr", icache_addr_o, 32'd0);
        chk("rst_daddr", dcache_addr_o, 32'd0);
        cacop_valid_i = 1'b1;
        #1;
        chk("rst_stall_comb", 32'(stall_o), 32'd1);
        @(negedge clk);
        cacop_valid_i = 1'b0;
        rst = 1'b0;

        // Directed scenarios
        run_op(5'b01001, 32'h0000_1040, 32'hDEAD_BEEF, 2, 1'b0);
        idle_cycle(1'b0);
        run_op(5'b10000, 32'h1234_5678, 32'h1C00_0100, 0, 1'b0);
        run_op(5'b11001, 32'h0000_2000, 32'h0000_3000, 0, 1'b0);
        run_op(5'b00010, 32'h0000_2000, 32'h0000_3000, 0, 1'b0);
        run_op(5'b01001, 32'h0000_4000, 32'h0, -1, 1'b0);
        run_op(5'b01001, 32'h0000_4040, 32'h0, TMO - 1, 1'b0);
        run_op(5'b00001, 32'h0000_5000, 32'h0, 4, 1'b1);
        repeat (4) idle_cycle(1'b1);

        // Reset during REQ: the aborted op must never complete
        @(negedge clk);
        cacop_valid_i = 1'b1;
        cacop_op_i    = 5'b01001;
        cacop_vaddr_i = 32'h0000_6000;
        icache_ack_i  = 1'b0;
        dcache_ack_i  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_dreq", 32'(dcache_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cacop_valid_i = 1'b0;
        #1;
        chk("post_rst_ready", 32'(ready_o), 32'd1);
        chk("post_rst_dreq",  32'(dcache_req_o), 32'd0);
        chk("post_rst_done",  32'(done_o), 32'd0);
        repeat (3) idle_cycle(1'b0);
        run_op(5'b01000, 32'h0000_7000, 32'h0, 1, 1'b0);

        // Randomized ops
        for (int n = 0; n < 60; n++) begin
            int a;
            a = int'($urandom_range(0, 10)) - 1;
            run_op(5'($urandom), $urandom, $urandom, a, 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cacop_ctrl.md
# cacop_ctrl

Sequences CACOP cache-maintenance instructions issued from the commit stage into the ICache or DCache maintenance port. It decodes `cacop_op`, picks the target cache and the address to use, and holds the request until the cache acknowledges. It stalls commit while the operation is in flight and pulses completion. A watchdog bounds the wait so that a lost acknowledge cannot hang the core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum number of cycles in REQ before the operation is forcibly completed with an error.

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cacop_valid_i`  in  1  commit-stage CACOP is present; held stable while `stall_o` is high.
- `cacop_op_i`  in  5  CACOP code: [2:0] target (0 = ICache, 1 = DCache, other = none); [4:3] mode.
- `cacop_vaddr_i`  in  32  virtual address (index source for modes 0 and 1).
- `cacop_paddr_i`  in  32  translated physical address (used for mode 2).
- `ready_o`  out  1  controller is idle and can accept.
- `stall_o`  out  1  commit must hold the current instruction.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  valid with `done_o`; 1 = watchdog timeout.
- `icache_req_o`  out  1  ICache maintenance request.
- `icache_mode_o`  out  2  mode forwarded to ICache.
- `icache_addr_o`  out  32  address forwarded to ICache.
- `icache_ack_i`  in  1  ICache has completed the request.
- `dcache_req_o`  out  1  DCache maintenance request.
- `dcache_mode_o`  out  2  mode forwarded to DCache.
- `dcache_addr_o`  out  32  address forwarded to DCache.
- `dcache_ack_i`  in  1  DCache has completed the request (including any writeback).

## Operation
- Modes:
  - 0 = store-tag init
  - 1 = index invalidate/writeback
  - 2 = hit invalidate
  - 3 = no-op
- Registered on accept:
  - target
  - mode
  - address: `cacop_paddr_i` when mode == 2, else `cacop_vaddr_i`
- A no-op is any operation with mode 3 or target ∉ {0, 1}. It touches no cache.
- States:
  - IDLE → (`cacop_valid_i`) → REQ if the op is real, DONE if it is a no-op. `ready_o` = 1 only in IDLE.
  - REQ → drive `*_req_o` = 1 on the selected cache only, with registered mode and address held stable. Go to DONE when the selected cache's ack = 1 (sampled the same cycle as the request), or when the timeout counter reaches `TIMEOUT_CYCLES`-1 (sets the err flag).
  - DONE → `done_o` = 1 and `err_o` = err flag; go to IDLE unconditionally.
- `stall_o` = (state == REQ) | (state == IDLE & `cacop_valid_i`). `stall_o` is low in DONE, so commit retires the CACOP in the DONE cycle.
- The ack of the non-selected cache is ignored. Any ack outside REQ is ignored.
- The timeout counter:
  - width is `$clog2(TIMEOUT_CYCLES+1)`
  - clears on entry to REQ
  - increments every REQ cycle without an ack
  - saturates; it never wraps
- If ack and the timeout condition occur in the same cycle, ack wins and `err_o` = 0.
- No flush input: an accepted CACOP always runs to DONE, because commit-stage instructions are non-speculative.

## Timing
- Reset values:
  - state = IDLE
  - `ready_o` = 1
  - all `*_req_o` = 0
  - `stall_o` = `cacop_valid_i` (combinational)
  - `done_o` = 0
  - `err_o` = 0
  - modes and addresses = 0
  - counter = 0
- Real-op latency is accept cycle T, REQ from T+1, ack at T+1+k, then `done_o` at T+2+k. The minimum is 2 cycles from accept to `done_o`.
- A no-op gives `done_o` at T+1.
- The request handshake is level-based: `req_o` stays high until the ack cycle inclusive, then drops in DONE.
- A back-to-back CACOP can be accepted in the IDLE cycle right after DONE, which is at least 3 cycles per op.
- `rst` asserted in any state forces IDLE on the next edge: `req_o` drops, and no `done_o` is issued for the aborted op.

## Test plan
- DCache index invalidate: op = 5'b01001, vaddr = 0x0000_1040, ack 3 cycles after the request → `dcache_req_o` high for 3 cycles with addr 0x0000_1040 and mode 1; `icache_req_o` stays 0; `done_o` = 1 and `err_o` = 0 one cycle after ack; `stall_o` low in that cycle.
- ICache hit invalidate, same-cycle ack: op = 5'b10000, paddr = 0x1C00_0100 → `icache_addr_o` = 0x1C00_0100 and mode 2; `done_o` 2 cycles after accept.
- No-ops: op = 5'b11001 (mode 3) and op = 5'b00010 (target 2) → no `*_req_o`; `done_o` at T+1 with `err_o` = 0.
- Timeout: `TIMEOUT_CYCLES` = 8, DCache never acks → `dcache_req_o` high for exactly 8 cycles; `done_o` = 1 and `err_o` = 1; back to IDLE. Repeat with the ack landing on the 8th cycle → `err_o` = 0.
- Stray and wrong-cache acks: `icache_ack_i` pulses during a DCache op, and `dcache_ack_i` pulses while IDLE → no effect on state or outputs.
- Reset in REQ: assert `rst` for 1 cycle mid-wait → next cycle IDLE, `req_o` = 0, `done_o` never asserted; a following op completes normally.
